// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I load/store funct3 codes
//   - FSM state encoding
//   - WORD_W, the data word width
//   - helpers for funct3 legality and the low-address alignment mask
package lsu_pkg;

  localparam int WORD_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4
  } lsu_state_e;

  // Stores only have B/H/W; loads add the unsigned B/H variants.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) begin
      ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

  // Address bits that must be zero for a naturally aligned access.
  function automatic logic [1:0] align_mask(input logic [2:0] f3);
    logic [1:0] m;
    case (f3[1:0])
      2'b01:   m = 2'b01;
      2'b10:   m = 2'b11;
      default: m = 2'b00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic shared by loads and stores.
//   word       in   WORD_W  memory word (read data for loads, merge buffer for stores)
//   addr_lo    in   2       byte offset within the word
//   funct3     in   3       access size / signedness
//   store_data in   WORD_W  right-aligned store data
//   load_data  out  WORD_W  selected lane, sign- or zero-extended
//   merge_word out  WORD_W  word with the addressed lane(s) replaced by store data
module lsu_align
  import lsu_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [1:0]        addr_lo,
  input  logic [2:0]        funct3,
  input  logic [WORD_W-1:0] store_data,
  output logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] merge_word
);

  logic [WORD_W-1:0] shifted;
  logic [WORD_W-1:0] store_rep;
  logic [3:0]        byte_en;

  // Bring the addressed lane down to bit 0 before extending.
  assign shifted = word >> {addr_lo, 3'b000};

  always_comb begin
    load_data = word;
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data = {24'd0, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data = {16'd0, shifted[15:0]};
      default: load_data = word;
    endcase
  end

  // Replicate the store data across every lane, then let byte_en pick
  // which lanes actually take it; avoids a variable shift on the write path.
  always_comb begin
    store_rep = store_data;
    byte_en   = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        store_rep = {4{store_data[7:0]}};
        byte_en   = 4'b0001 << addr_lo;
      end
      2'b01: begin
        store_rep = {2{store_data[15:0]}};
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_rep = store_data;
        byte_en   = 4'b1111;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merge_word[8*gi +: 8] = byte_en[gi] ? store_rep[8*gi +: 8] : word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: turns RV32I byte-addressed loads/stores into accesses on a
// word-wide data memory (combinational read, write on posedge). Sub-word
// stores are a read-modify-write over two memory cycles.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   - misaligned H/W requests complete with resp_err=1, no memory access
//   undefined - the offending low address bits are cleared and the access proceeds
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_we, req_funct3         store/load select and RV32I funct3
//   req_addr, req_wdata        byte address, right-aligned store data
//   resp_valid                 one-cycle completion pulse
//   resp_rdata, resp_err       extended load data, error flag
//   mem_read, mem_write        memory strobes (never both high)
//   mem_addr, mem_wdata        word address and write data
//   mem_rdata                  combinational read data from memory
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);

  lsu_state_e        state_reg, state_next;
  logic [2:0]        f3_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [WORD_W-1:0] wdata_reg;
  logic [WORD_W-1:0] buf_reg;
  logic [WORD_W-1:0] rdata_reg;
  logic              err_reg;

  logic              accept;
  logic              req_bad;
  logic [ADDR_W-1:0] addr_eff;
  logic [WORD_W-1:0] align_word;
  logic [WORD_W-1:0] load_data;
  logic [WORD_W-1:0] merge_word;

`ifdef LSU_MISALIGN_TRAP_EN
  assign addr_eff = req_addr;
  assign req_bad  = !f3_legal(req_we, req_funct3) ||
                    (|(req_addr[1:0] & align_mask(req_funct3)));
`else
  // Misaligned accesses are silently rounded down to the access size.
  assign addr_eff = {req_addr[ADDR_W-1:2], req_addr[1:0] & ~align_mask(req_funct3)};
  assign req_bad  = !f3_legal(req_we, req_funct3);
`endif

  // The lane logic sees the live read data while loading and the captured
  // word while writing back a sub-word store.
  assign align_word = (state_reg == ST_LOAD) ? mem_rdata : buf_reg;

  lsu_align u_align (
    .word       (align_word),
    .addr_lo    (addr_reg[1:0]),
    .funct3     (f3_reg),
    .store_data (wdata_reg),
    .load_data  (load_data),
    .merge_word (merge_word)
  );

  // Every output here depends only on state_reg and the latched request, so
  // an asynchronous reset drops them all without waiting for a clock.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_reg)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (req_bad) begin
            state_next = ST_DONE;
          end else if (!req_we) begin
            state_next = ST_LOAD;
          end else if (req_funct3 == F3_W) begin
            state_next = ST_WRITE;
          end else begin
            state_next = ST_RMW_RD;
          end
        end
      end
      ST_LOAD: begin
        mem_read   = 1'b1;
        mem_addr   = addr_reg[ADDR_W-1:2];
        state_next = ST_DONE;
      end
      ST_RMW_RD: begin
        mem_read   = 1'b1;
        mem_addr   = addr_reg[ADDR_W-1:2];
        state_next = ST_WRITE;
      end
      ST_WRITE: begin
        // For SW every lane is enabled, so the merge output is wdata itself.
        mem_write  = 1'b1;
        mem_addr   = addr_reg[ADDR_W-1:2];
        mem_wdata  = merge_word;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        resp_valid = 1'b1;
        resp_err   = err_reg;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      f3_reg    <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      buf_reg   <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        f3_reg    <= req_funct3;
        addr_reg  <= addr_eff;
        wdata_reg <= req_wdata;
        err_reg   <= req_bad;
        if (req_bad) begin
          rdata_reg <= '0;
        end
      end
      // Stores never touch rdata_reg, so the last load result persists.
      if (state_reg == ST_LOAD) begin
        rdata_reg <= load_data;
      end
      if (state_reg == ST_RMW_RD) begin
        buf_reg <= mem_rdata;
      end
    end
  end

  assign resp_rdata = rdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory: combinational read, write on posedge.
  logic [31:0] tb_mem [0:63];
  assign mem_rdata = tb_mem[mem_addr];
  always @(posedge clk) begin
    if (mem_write) tb_mem[mem_addr] <= mem_wdata;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
    int          nrd;
    int          nwr;
    bit          chk_word;
    int          widx;
    logic [31:0] wval;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int checks    = 0;
  int failures  = 0;
  int nrd_cnt   = 0;
  int nwr_cnt   = 0;
  int resp_cnt  = 0;
  bit both_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Response monitor: pops the scoreboard and compares on each pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      nrd_cnt = 0;
      nwr_cnt = 0;
    end else begin
      if (mem_read && mem_write) both_seen = 1'b1;
      if (mem_read) nrd_cnt++;
      if (mem_write) nwr_cnt++;
      if (resp_valid) begin
        resp_cnt++;
        checks++;
        assert (sb_q.size() != 0) else begin
          failures++;
          $error("FAIL unexpected_resp observed=resp_valid expected=no_response");
        end
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          $display("resp %0d: err=%0d rdata=0x%08h cyc=%0d reads=%0d writes=%0d",
                   resp_cnt, resp_err, resp_rdata, cyc, nrd_cnt, nwr_cnt);
          chk("resp_err", {31'd0, resp_err}, {31'd0, mon_e.err});
          chk("resp_rdata", resp_rdata, mon_e.rdata);
          chk("resp_cycle", cyc, mon_e.cyc);
          chk("mem_read_cycles", nrd_cnt, mon_e.nrd);
          chk("mem_write_cycles", nwr_cnt, mon_e.nwr);
          if (mon_e.chk_word) chk("mem_word", tb_mem[mon_e.widx], mon_e.wval);
        end
        nrd_cnt = 0;
        nwr_cnt = 0;
      end
    end
  end

  // Drive one request; push its expectation just before the accepting edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [7:0] a,
                       input logic [31:0] wd, input bit hold, input logic err,
                       input logic [31:0] rd, input int lat, input int nr, input int nw,
                       input bit cw, input int widx, input logic [31:0] wval);
    int   g;
    exp_t e;
    g = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    while (!req_ready && g < 40) begin
      @(negedge clk);
      g++;
    end
    checks++;
    assert (g < 40) else begin
      failures++;
      $error("FAIL accept_timeout observed=%0d expected<40", g);
    end
    e.err = err; e.rdata = rd; e.cyc = cyc + lat; e.nrd = nr; e.nwr = nw;
    e.chk_word = cw; e.widx = widx; e.wval = wval;
    sb_q.push_back(e);
    if (!hold) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic ld_ok(input logic [2:0] f3, input logic [7:0] a, input logic [31:0] rd,
                       input bit hold);
    issue(1'b0, f3, a, 32'd0, hold, 1'b0, rd, 2, 1, 0, 1'b0, 0, 32'd0);
  endtask

  task automatic st_ok(input logic [2:0] f3, input logic [7:0] a, input logic [31:0] wd,
                       input logic [31:0] rd_keep, input int widx, input logic [31:0] wval);
    if (f3 == F3_W) issue(1'b1, f3, a, wd, 1'b0, 1'b0, rd_keep, 2, 0, 1, 1'b1, widx, wval);
    else            issue(1'b1, f3, a, wd, 1'b0, 1'b0, rd_keep, 3, 1, 1, 1'b1, widx, wval);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb_q.size() != 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    checks++;
    assert (sb_q.size() == 0) else begin
      failures++;
      $error("FAIL drain_timeout observed=%0d expected=0", sb_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int g;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = '0;
    req_wdata  = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_mem_addr", {26'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;

    // Preload memory through the unit with word stores.
    st_ok(F3_W, 8'h04, 32'h0000_0100, 32'd0, 1, 32'h0000_0100);  drain();
    st_ok(F3_W, 8'h08, 32'h0000_0000, 32'd0, 2, 32'h0000_0000);  drain();
    st_ok(F3_W, 8'h0C, 32'h1122_3344, 32'd0, 3, 32'h1122_3344);  drain();
    st_ok(F3_W, 8'hFC, 32'h8011_2233, 32'd0, 63, 32'h8011_2233); drain();
    st_ok(F3_W, 8'h10, 32'hDEAD_BEEF, 32'd0, 4, 32'hDEAD_BEEF);  drain();

    ld_ok(F3_W, 8'h04, 32'h0000_0100, 1'b0); drain();

    // Byte store by read-modify-write, then both byte load flavours.
    st_ok(F3_B, 8'h05, 32'h0000_00AB, 32'h0000_0100, 1, 32'h0000_AB00); drain();
    ld_ok(F3_BU, 8'h05, 32'h0000_00AB, 1'b0); drain();
    ld_ok(F3_B,  8'h05, 32'hFFFF_FFAB, 1'b0); drain();

    // Upper-half store, then signed and unsigned half loads.
    st_ok(F3_H, 8'h0A, 32'h0000_8001, 32'hFFFF_FFAB, 2, 32'h8001_0000); drain();
    ld_ok(F3_H,  8'h0A, 32'hFFFF_8001, 1'b0); drain();
    ld_ok(F3_HU, 8'h0A, 32'h0000_8001, 1'b0); drain();

    // Misaligned word load.
`ifdef LSU_MISALIGN_TRAP_EN
    issue(1'b0, F3_W, 8'h06, 32'd0, 1'b0, 1'b1, 32'd0, 1, 0, 0, 1'b0, 0, 32'd0);
`else
    ld_ok(F3_W, 8'h06, 32'h0000_AB00, 1'b0);
`endif
    drain();

    // Illegal funct3 errors in either build; memory stays untouched.
    issue(1'b0, 3'b011, 8'h04, 32'd0, 1'b0, 1'b1, 32'd0, 1, 0, 0, 1'b0, 0, 32'd0);
    drain();
    issue(1'b1, 3'b100, 8'h04, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd0, 1, 0, 0, 1'b1, 1, 32'h0000_AB00);
    drain();

    // Top byte address maps to the last word.
    ld_ok(F3_B, 8'hFF, 32'hFFFF_FF80, 1'b0); drain();

    // Misaligned half store.
`ifdef LSU_MISALIGN_TRAP_EN
    issue(1'b1, F3_H, 8'h0B, 32'h0000_1234, 1'b0, 1'b1, 32'd0, 1, 0, 0, 1'b1, 2, 32'h8001_0000);
`else
    st_ok(F3_H, 8'h0B, 32'h0000_1234, 32'hFFFF_FF80, 2, 32'h1234_0000);
`endif
    drain();

    // Three loads with req_valid held throughout.
    base = resp_cnt;
    ld_ok(F3_W,  8'h04, 32'h0000_AB00, 1'b1);
    ld_ok(F3_W,  8'h10, 32'hDEAD_BEEF, 1'b1);
    ld_ok(F3_BU, 8'h0C, 32'h0000_0044, 1'b0);
    drain();
    chk("burst_resp_count", resp_cnt - base, 32'd3);

    // Reset during the WRITE state of a byte store.
    issue(1'b1, F3_B, 8'h0C, 32'h0000_0055, 1'b0, 1'b0, 32'h0000_0044, 3, 1, 1, 1'b0, 0, 32'd0);
    g = 0;
    while (!mem_write && g < 10) begin
      @(negedge clk);
      g++;
    end
    chk("reach_write_state", {31'd0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    chk("rstmid_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rstmid_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rstmid_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rstmid_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstmid_word_kept", tb_mem[3], 32'h1122_3344);
    chk("rstmid_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rstmid_resp_rdata", resp_rdata, 32'd0);

    ld_ok(F3_W, 8'h0C, 32'h1122_3344, 1'b0); drain();

    chk("rd_wr_exclusive", {31'd0, both_seen}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the word-wide data memory (6-bit word address, 32-bit data, separate MemRead/MemWrite, combinational read, write on posedge clk).
- Converts RV32I byte-addressed loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses.
- Sub-word stores are done as a two-cycle read-modify-write.
- Loads are sign- or zero-extended; the unit presents a valid/ready request and response handshake to the core.

Parameters:
- ADDR_W, 8, byte-address width; the memory word address is ADDR_W-2 bits (6 at default).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data.
- resp_err  out  1  misaligned or illegal request; valid with resp_valid.
- mem_read  out  1  to memory MemRead.
- mem_write  out  1  to memory MemWrite.
- mem_addr  out  ADDR_W-2  word address.
- mem_wdata  out  32  write word.
- mem_rdata  in  32  memory read data, combinational.

Interface decision: one clock, clk; reset rst_n is asynchronous, active-low.

Behaviour:
- States: IDLE, LOAD, RMW_RD, WRITE, DONE.
- Reset (async, rst_n=0): state=IDLE, req_ready=1 (req_ready=1 only in IDLE), resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- Accept: req_valid & req_ready in IDLE at cycle N. The request is latched: we, funct3, addr, wdata.
- Outputs: mem_read/mem_write/mem_addr are decoded from registered state and latched request only; never from req_* directly. mem_read and mem_write are never both 1.
- Decode at accept:
  - Illegal funct3 (loads 011/110/111; stores other than 000/001/010) -> DONE, resp_err=1.
  - Misaligned (H at addr[0]=1; W at addr[1:0]!=0) -> DONE, resp_err=1. No memory access in either error case.
  - Load -> LOAD.
  - SW -> WRITE.
  - SB/SH -> RMW_RD.
- LOAD: mem_read=1, mem_addr=addr[ADDR_W-1:2]. Select the byte/half lane by addr[1:0] from mem_rdata, extend it (LB/LH sign, LBU/LHU zero), register into resp_rdata -> DONE.
- RMW_RD: mem_read=1. Latch mem_rdata into a merge buffer -> WRITE.
- WRITE: mem_write=1, mem_addr as latched.
  - SW: mem_wdata = wdata.
  - SB/SH: mem_wdata = buffer with the addressed lane replaced by wdata[7:0] or wdata[15:0].
  - Next state -> DONE.
- DONE: resp_valid=1 for exactly one cycle -> IDLE.
  - resp_err reflects the request; resp_rdata=0 on error.
  - resp_rdata holds its value until the next load response; stores leave it unchanged.
- Latency (accept to resp_valid): load 2 cycles, SW 2, SB/SH 3, error 1.
- Back-to-back: the next accept is possible in the cycle after DONE. Peak throughput is one load per 3 cycles.
- req_valid while busy is ignored; the requester must hold it.
- Reset mid-operation: outputs drop immediately with no clock needed. A write in progress is abandoned; memory is unchanged if rst_n falls before the WRITE posedge.
- Address wrap: none. The top byte address maps to the last word.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned requests complete with resp_err=1 and no memory access, as described above.
- Undefined: alignment checks are removed. Low address bits below the access size are forced to 0 (H clears addr[0]; W clears addr[1:0]), and the access proceeds normally with resp_err=0. Illegal funct3 always errors, with or without the macro.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - State encoding constants.
  - WORD_W=32.
- One sub-module, lsu_align (combinational):
  - Lane extract plus sign/zero extend for loads.
  - Lane merge for stores.
  - Reused for both directions.

Test Plan:
1. Memory word1=0x00000100; LW addr 0x04 -> resp_valid at N+2, resp_rdata=0x00000100, resp_err=0; one mem_read cycle at N+1.
2. SB wdata 0x000000AB at 0x05 over word1=0x00000100 -> mem_read at N+1, mem_write at N+2 with mem_wdata=0x0000AB00, resp at N+3. Then LBU 0x05 -> 0x000000AB; LB 0x05 -> 0xFFFFFFAB.
3. SH wdata 0x00008001 at 0x0A over word2=0 -> word2=0x80010000. LH 0x0A -> 0xFFFF8001; LHU 0x0A -> 0x00008001.
4. LW at 0x06:
   - With LSU_MISALIGN_TRAP_EN: resp at N+1, resp_err=1, resp_rdata=0, no mem_read/mem_write pulse.
   - Without: reads word1, resp_err=0.
5. Illegal load funct3=011 -> resp_err=1 at N+1 in both builds. Reset pulled low during the WRITE state of an SB -> mem_write=0 immediately, word unchanged, req_ready=1 after release.
6. Back-to-back with req_valid held through 3 loads -> req_ready low between accepts, exactly 3 resp_valid pulses with correct data in order, mem_read and mem_write never both high.
